uart_loader: RTL and testbench
==============================

# uart_loader

Boot-time program loader between the FPGA UART receiver and the single-port RAM that the request unit serves. It receives a framed program image over the UART byte interface and packs bytes into 32-bit little-endian words. It writes the words to RAM at consecutive word addresses and holds the CPU in reset until the image is fully and correctly loaded. It reports ACK/NAK back over the UART transmit interface.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of first loaded word
- MAX_WORDS, 4096, largest accepted word count

Ports:
- clk  in  1  system clock (hz100 at top)
- rst  in  1  synchronous, active-high reset
- rxdata  in  8  received byte
- rxready  in  1  rxdata valid
- rxclk  out  1  loader ready to accept a byte; byte consumed on cycle with rxready && rxclk
- txdata  out  8  status byte
- txclk  out  1  one-cycle transmit strobe
- txready  in  1  transmitter can accept a byte
- ramaddr  out  32  RAM byte address (word aligned)
- ramstore  out  32  RAM write data
- ramWen  out  1  RAM write enable, one cycle per word
- cpu_hold  out  1  hold CPU in reset (drives into CPU reset logic)
- done  out  1  load complete, sticky
- error  out  1  load failed, sticky until next sync byte or rst

## Operation
- Frame: sync 8'hA5, count low byte, count high byte, count×4 data bytes (LSB first per word), checksum byte.
- States:
  - IDLE: accept bytes; discard non-A5 bytes; A5 → LEN0.
  - LEN0 → LEN1: capture count.
  - LEN1 → ERROR if count > MAX_WORDS; → CSUM if count = 0; else → DATA.
  - DATA: accept 4 bytes into the packer; after the 4th byte → WRITE.
  - WRITE: ramWen=1 for one cycle with addr = BASE_ADDR + 4×index, then index+1. → CSUM if index+1 = count, else → DATA.
  - CSUM: byte compare (see Configuration); → DONE or ERROR.
  - DONE: terminal until rst.
  - ERROR: accepts bytes; A5 clears error, resets index, and → LEN0.
- rxclk=1 in IDLE, LEN0, LEN1, DATA, CSUM, ERROR; 0 in WRITE and DONE.
- Index and count are 16-bit. Address arithmetic is 32-bit and wraps modulo 2^32.
- Running checksum = XOR of all data bytes. It clears on the sync byte.
- On entry to DONE, queue ACK 8'h06. On entry to ERROR, queue NAK 8'h15.
- Queued byte: when txready=1, drive txdata and pulse txclk for one cycle, then clear the queue. txdata holds its last value afterwards.
- cpu_hold=1 from reset until DONE; 0 only in DONE.
- done = (state==DONE); error = (state==ERROR).

## Timing
- While rst is high and in the cycle after: state IDLE, cpu_hold=1, done=0, error=0, ramWen=0, ramaddr=BASE_ADDR, ramstore=0, txclk=0, txdata=0, index=0. rxclk=1 from the first cycle after rst deasserts.
- Byte to state advance: 1 cycle. At most one byte per cycle.
- 4th data byte accepted in cycle N → ramWen high in cycle N+1. No byte is accepted in N+1, so the minimum word period is 5 cycles.
- cpu_hold falls and done rises in the cycle after the checksum byte is accepted.
- ACK/NAK txclk fires the first cycle with txready=1 at or after that point.
- rst mid-frame: the partial word is discarded; words already written stay in RAM; no status byte is sent.
- rxready held high with rxclk=0 (WRITE): the byte is not consumed and is taken in the next DATA or CSUM cycle.
- A5 byte inside DATA is treated as data, not sync.

## Configuration
- UART_LOADER_CHECKSUM_EN defined: in CSUM, the received byte must equal the running XOR; a mismatch → ERROR.
- UART_LOADER_CHECKSUM_EN undefined: the checksum byte is consumed and ignored, always → DONE, and the XOR logic is not built.

## Structure
- Package loader_pkg holds:
  - the state enum (IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERROR);
  - the SYNC_BYTE, ACK_BYTE, NAK_BYTE constants;
  - the 16-bit count typedef.
- Sub-module byte_packer: a 2-bit lane counter plus a 32-bit shift register. It has inputs shift enable and clear, and outputs the assembled word and a word_full flag.

## Test plan
- Reset, then A5 00 00 00 (checksum 0) → one ACK byte, 06; no ramWen; done=1; cpu_hold=0.
- A5 02 00, 78 56 34 12, EF BE AD DE, checksum → ramWen writes 12345678 to addr 0 and DEADBEEF to addr 4; then ACK; done=1.
- Same frame with a wrong checksum → NAK 15, error=1, cpu_hold=1. With UART_LOADER_CHECKSUM_EN undefined, the same frame gives ACK instead.
- Count 4097 with MAX_WORDS=4096 → ERROR after LEN1, NAK. A following A5 01 00 … frame → error clears and the load completes.
- Garbage bytes 00 FF 13 before A5 → ignored. rst asserted after 2 data bytes → IDLE, cpu_hold=1, no ramWen, no txclk.
- rxready held high continuously through a one-word frame → exactly 4 data bytes consumed; rxclk=0 in the WRITE cycle; ramWen asserted once.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared types and framing constants for the UART boot loader.
// Imported by the loader top and its bench.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;

    typedef logic [15:0] count_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

endpackage

// File: rtl/uart_loader_if.sv
// UART byte channels and RAM write port seen by the boot loader.
// master = loader side, slave = UART/RAM side.
interface uart_loader_if;

    logic [7:0]  rxdata;
    logic        rxready;
    logic        rxclk;
    logic [7:0]  txdata;
    logic        txclk;
    logic        txready;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        ramWen;

    modport master (
        input  rxdata, rxready, txready,
        output rxclk, txdata, txclk, ramaddr, ramstore, ramWen
    );

    modport slave (
        output rxdata, rxready, txready,
        input  rxclk, txdata, txclk, ramaddr, ramstore, ramWen
    );

endinterface

// File: rtl/uart_loader_byte_packer.sv
// Packs received bytes LSB-first into a 32-bit little-endian word.
// word_full flags the shift that completes the current word.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        shift,
    input  logic        clear,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0] lane;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane <= '0;
            word <= '0;
        end else if (shift) begin
            lane <= lane + 2'd1;
            word <= {din, word[31:8]};
        end
    end

    assign word_full = shift && (lane == 2'd3);

endmodule

// File: rtl/uart_loader.sv
// Boot loader: framed UART image -> RAM words; holds the CPU until loaded.
// Define UART_LOADER_CHECKSUM_EN to verify the trailing XOR checksum byte.
module uart_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic          clk,
    input  logic          rst,
    uart_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    state_t      state;
    count_t      count;
    count_t      index;
    count_t      len;
    logic        tx_pend;
    logic        take;
    logic        is_sync;
    logic        shift;
    logic        clear;
    logic        word_full;
    logic        csum_ok;
    logic [31:0] word;

    assign take    = bus.rxready && bus.rxclk;
    assign is_sync = take && (bus.rxdata == SYNC_BYTE);
    assign shift   = take && (state == DATA);
    assign clear   = is_sync && (state == IDLE || state == ERROR);
    assign len     = {bus.rxdata, count[7:0]};

    assign bus.txclk    = tx_pend && bus.txready;
    assign bus.ramstore = word;

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .shift     (shift),
        .clear     (clear),
        .din       (bus.rxdata),
        .word      (word),
        .word_full (word_full)
    );

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (rst || clear)
            csum <= '0;
        else if (shift)
            csum <= csum ^ bus.rxdata;
    end

    assign csum_ok = (bus.rxdata == csum);
`else
    assign csum_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            index       <= '0;
            bus.rxclk   <= 1'b0;
            bus.ramWen  <= 1'b0;
            bus.ramaddr <= BASE_ADDR;
            bus.txdata  <= '0;
            tx_pend     <= 1'b0;
            cpu_hold    <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            bus.ramWen <= 1'b0;
            if (bus.txclk)
                tx_pend <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.rxclk <= 1'b1;
                    if (is_sync) begin
                        state <= LEN0;
                        index <= '0;
                    end
                end
                LEN0: if (take) begin
                    count <= {8'h00, bus.rxdata};
                    state <= LEN1;
                end
                LEN1: if (take) begin
                    count <= len;
                    if (32'(len) > MAX_WORDS) begin
                        state      <= ERROR;
                        error      <= 1'b1;
                        bus.txdata <= NAK_BYTE;
                        tx_pend    <= 1'b1;
                    end else if (len == '0) begin
                        state <= CSUM;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (word_full) begin
                    state       <= WRITE;
                    bus.rxclk   <= 1'b0;
                    bus.ramWen  <= 1'b1;
                    bus.ramaddr <= BASE_ADDR + {14'd0, index, 2'b00};
                end
                WRITE: begin
                    index     <= index + 16'd1;
                    bus.rxclk <= 1'b1;
                    state     <= (index + 16'd1 == count) ? CSUM : DATA;
                end
                CSUM: if (take) begin
                    bus.txdata <= csum_ok ? ACK_BYTE : NAK_BYTE;
                    tx_pend    <= 1'b1;
                    if (csum_ok) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        cpu_hold  <= 1'b0;
                        bus.rxclk <= 1'b0;
                    end else begin
                        state <= ERROR;
                        error <= 1'b1;
                    end
                end
                DONE: ;
                ERROR: if (is_sync) begin
                    state <= LEN0;
                    index <= '0;
                    error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: RAM writes and status bytes are predicted
// when frames are built and checked by a monitor as the DUT emits them.
`timescale 1ns/1ps
module tb_uart_loader;
    import loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_hold, done, error;

    uart_loader_if bus ();

    uart_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (4096)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_wen = 0;
    int n_tx = 0;
    int base_w, base_t, leaks;
    logic [63:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  stim[$];
    logic [7:0]  sum;
    logic [63:0] mon_w;
    logic [7:0]  mon_t;
    logic        exp_err, exp_done;
    logic [7:0]  exp_stat;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.ramWen) begin
            n_wen++;
            chk("wr_rxclk", 32'(bus.rxclk), 32'd0);
            chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
            if (exp_wr.size() > 0) begin
                mon_w = exp_wr.pop_front();
                chk("wr_addr", bus.ramaddr, mon_w[63:32]);
                chk("wr_data", bus.ramstore, mon_w[31:0]);
            end
        end
        if (bus.txclk) begin
            n_tx++;
            chk("tx_expected", 32'(exp_tx.size() > 0), 32'd1);
            if (exp_tx.size() > 0) begin
                mon_t = exp_tx.pop_front();
                chk("tx_byte", 32'(bus.txdata), 32'(mon_t));
            end
        end
    end

    task automatic hdr(input logic [15:0] cnt);
        stim.push_back(SYNC_BYTE);
        stim.push_back(cnt[7:0]);
        stim.push_back(cnt[15:8]);
        sum = 8'h00;
    endtask

    task automatic add_word(input logic [31:0] a, input logic [31:0] d);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = d[8*i +: 8];
            stim.push_back(b);
            sum = sum ^ b;
        end
        exp_wr.push_back({a, d});
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken,
    // leaving rxready high so back-to-back sends stream continuously.
    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.rxdata  = b;
        bus.rxready = 1'b1;
        while (!bus.rxclk && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rx_timeout", 32'(n < 40), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_all();
        while (stim.size() > 0)
            send(stim.pop_front());
        bus.rxready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rxready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_wen", 32'(bus.ramWen), 32'd0);
        chk("rst_addr", bus.ramaddr, 32'h0);
        chk("rst_store", bus.ramstore, 32'h0);
        chk("rst_txclk", 32'(bus.txclk), 32'd0);
        chk("rst_txdata", 32'(bus.txdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rxclk", 32'(bus.rxclk), 32'd1);
        chk("post_hold", 32'(cpu_hold), 32'd1);
    endtask

    task automatic drain(input string tag);
        repeat (4) @(negedge clk);
        chk({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
        chk({tag, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.rxdata  = 8'h00;
        bus.rxready = 1'b0;
        bus.txready = 1'b1;
        @(negedge clk);
        do_reset();

        // Empty image, ACK held back until the transmitter is ready.
        bus.txready = 1'b0;
        base_w = n_wen;
        hdr(16'd0);
        stim.push_back(sum);
        exp_tx.push_back(ACK_BYTE);
        send_all();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_hold", 32'(cpu_hold), 32'd0);
        chk("t1_rxclk", 32'(bus.rxclk), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_tx_wait", 32'(bus.txclk), 32'd0);
        @(posedge clk);
        #1 bus.txready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t1_txdata_hold", 32'(bus.txdata), 32'(ACK_BYTE));
        chk("t1_txclk_low", 32'(bus.txclk), 32'd0);
        chk("t1_no_wen", 32'(n_wen - base_w), 32'd0);
        drain("t1");

        // Two-word image with a good checksum.
        do_reset();
        hdr(16'd2);
        add_word(32'h0, 32'h1234_5678);
        add_word(32'h4, 32'hDEAD_BEEF);
        stim.push_back(sum);
        exp_tx.push_back(ACK_BYTE);
        send_all();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_hold", 32'(cpu_hold), 32'd0);
        drain("t2");

        // Same image with a corrupted checksum byte.
        do_reset();
`ifdef UART_LOADER_CHECKSUM_EN
        exp_err  = 1'b1;
        exp_done = 1'b0;
        exp_stat = NAK_BYTE;
`else
        exp_err  = 1'b0;
        exp_done = 1'b1;
        exp_stat = ACK_BYTE;
`endif
        hdr(16'd2);
        add_word(32'h0, 32'h1234_5678);
        add_word(32'h4, 32'hDEAD_BEEF);
        stim.push_back(sum ^ 8'hFF);
        exp_tx.push_back(exp_stat);
        send_all();
        chk("t3_err", 32'(error), 32'(exp_err));
        chk("t3_done", 32'(done), 32'(exp_done));
        chk("t3_hold", 32'(cpu_hold), 32'(!exp_done));
        drain("t3");

        // Oversized count, then recovery with a fresh sync byte.
        do_reset();
        hdr(16'd4097);
        exp_tx.push_back(NAK_BYTE);
        send_all();
        chk("t4_err", 32'(error), 32'd1);
        chk("t4_hold", 32'(cpu_hold), 32'd1);
        drain("t4_nak");
        hdr(16'd1);
        add_word(32'h0, 32'hCAFE_F00D);
        stim.push_back(sum);
        exp_tx.push_back(ACK_BYTE);
        send(stim.pop_front());
        chk("t4_err_clear", 32'(error), 32'd0);
        send_all();
        chk("t4_done", 32'(done), 32'd1);
        drain("t4");

        // Garbage before sync is ignored.
        do_reset();
        stim.push_back(8'h00);
        stim.push_back(8'hFF);
        stim.push_back(8'h13);
        hdr(16'd1);
        add_word(32'h0, 32'h0BAD_F00D);
        stim.push_back(sum);
        exp_tx.push_back(ACK_BYTE);
        send_all();
        chk("t5_done", 32'(done), 32'd1);
        drain("t5");

        // Reset after two data bytes: nothing written, nothing sent.
        do_reset();
        base_w = n_wen;
        base_t = n_tx;
        send(SYNC_BYTE);
        send(8'h01);
        send(8'h00);
        send(8'h11);
        send(8'h22);
        rst = 1'b1;
        bus.rxready = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_rst_hold", 32'(cpu_hold), 32'd1);
        chk("t6_rst_store", bus.ramstore, 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_no_wen", 32'(n_wen - base_w), 32'd0);
        chk("t6_no_tx", 32'(n_tx - base_t), 32'd0);
        chk("t6_hold", 32'(cpu_hold), 32'd1);
        hdr(16'd1);
        add_word(32'h0, 32'h0102_0304);
        stim.push_back(sum);
        exp_tx.push_back(ACK_BYTE);
        send_all();
        drain("t6");

        // rxready held high through a one-word frame and beyond.
        do_reset();
        base_w = n_wen;
        hdr(16'd1);
        add_word(32'h0, 32'h4433_2211);
        stim.push_back(sum);
        exp_tx.push_back(ACK_BYTE);
        while (stim.size() > 0)
            send(stim.pop_front());
        bus.rxdata = 8'h5A;
        leaks = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rxclk)
                leaks++;
        end
        bus.rxready = 1'b0;
        chk("t7_no_take", 32'(leaks), 32'd0);
        chk("t7_one_wen", 32'(n_wen - base_w), 32'd1);
        chk("t7_done", 32'(done), 32'd1);
        drain("t7");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
